// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: shared FSM encoding, config register map and vector helper
//   state_e      controller FSM states (IDLE=0, REQ=1, SERVICE=2)
//   ADDR_*       cfg_addr decode values for the config port
//   isr_vector   base + id*stride ISR address arithmetic
package irq_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK   = 2'd0;
    localparam logic [1:0] ADDR_PEND   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    function automatic logic [31:0] isr_vector(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [31:0] id
    );
        return base + stride * id;
    endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// irq_controller_prio_enc: fixed-priority encoder, lowest set index wins
//   req   in   N     candidate lines
//   valid out  1     any line set
//   id    out  ID_W  index of the lowest set line (0 when none)
module irq_controller_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scanning downward lets the lowest index overwrite any higher one.
    always_comb begin
        id = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) id = ID_W'(i);
    end

    assign valid = |req;

endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latching, maskable, fixed-priority interrupt controller
//   clk, rst            clock / asynchronous active-high reset
//   irq_in              edge-triggered request lines
//   cfg_we/addr/wdata   config write port (MASK, PEND W1C)
//   cfg_rdata           combinational read of MASK/PEND/STATUS
//   irq_req/ack/eoi     request-acknowledge-end handshake with the core
//   irq_vec, irq_id     ISR address and index of the request being served
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter int          W          = 16,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0010,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0002,
    parameter int          ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [W-1:0]       cfg_wdata,
    output logic [W-1:0]       cfg_rdata,
    output logic               irq_req,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic [31:0]        irq_vec,
    output logic [ID_W-1:0]    irq_id
);

    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               arm_q, arm_d;
    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        vec_q, vec_d;
    logic [NUM_IRQ-1:0] rise, ack_clr, w1c_clr, eligible;
    logic               sel_valid;
    logic [ID_W-1:0]    sel_id;
    logic               ack_ok;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    // prev resets to 0, so a line held high across reset would look like a
    // fresh edge on the first clock; arm_q suppresses edge capture for that
    // one edge so such a line must fall and rise again to fire.
    assign rise     = arm_q ? (irq_in & ~prev_q) : '0;
    assign ack_ok   = (state_q == ST_REQ) && irq_ack;
    assign ack_clr  = ack_ok ? (NUM_IRQ'(1) << id_q) : '0;
    assign w1c_clr  = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[NUM_IRQ-1:0] : '0;
    assign eligible = pend_q & mask_q;

    irq_controller_prio_enc #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_prio (
        .req   (eligible),
        .valid (sel_valid),
        .id    (sel_id)
    );

    always_comb begin
        prev_d = irq_in;
        arm_d  = 1'b1;
        // A new edge wins over any clear landing on the same clock.
        pend_d = (pend_q & ~(ack_clr | w1c_clr)) | rise;
        mask_d = (cfg_we && cfg_addr == ADDR_MASK) ? cfg_wdata[NUM_IRQ-1:0] : mask_q;
    end

    // Request fields are only loaded on IDLE->REQ, so they stay frozen
    // through REQ and SERVICE regardless of later mask/pend activity.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        vec_d   = vec_q;
        unique case (state_q)
            ST_IDLE: if (sel_valid) begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                id_d    = sel_id;
                vec_d   = isr_vector(VEC_BASE, VEC_STRIDE, 32'(sel_id));
            end
            ST_REQ: if (irq_ack) begin
                state_d = ST_SERVICE;
                req_d   = 1'b0;
            end
            ST_SERVICE: if (irq_eoi) state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            arm_q   <= 1'b0;
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            vec_q   <= VEC_BASE;
        end else begin
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            arm_q   <= arm_d;
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
        end
    end

    assign cfg_rdata = (cfg_addr == ADDR_MASK)   ? W'(mask_q) :
                       (cfg_addr == ADDR_PEND)   ? W'(pend_q) :
                       (cfg_addr == ADDR_STATUS) ? W'({state_q, id_q}) : '0;

    assign irq_req = req_q;
    assign irq_id  = id_q;
    assign irq_vec = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed and random checks of irq_controller against a behavioural model
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  irq_in = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] cfg_rdata;
    logic        irq_req;
    logic        irq_ack = 1'b0;
    logic        irq_eoi = 1'b0;
    logic [31:0] irq_vec;
    logic [1:0]  irq_id;

    int checks = 0;
    int errors = 0;

    // model: phase 0 idle, 1 requesting, 2 in service
    bit [3:0] m_pend, m_mask, m_prev;
    bit       m_armed;
    int       m_phase, m_id;

    irq_controller dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_req   (irq_req),
        .irq_ack   (irq_ack),
        .irq_eoi   (irq_eoi),
        .irq_vec   (irq_vec),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_armed = 0; m_phase = 0; m_id = 0;
    endtask

    task automatic model_edge(input bit [3:0] irq, input bit we, input bit [1:0] addr,
                              input bit [15:0] wd, input bit ack, input bit eoi);
        bit [3:0] np;
        int win;
        for (int i = 0; i < 4; i++) begin
            bit rose, kill;
            rose = m_armed && irq[i] && !m_prev[i];
            kill = (m_phase == 1 && ack && i == m_id) || (we && addr == 1 && wd[i]);
            np[i] = rose || (m_pend[i] && !kill);
        end
        win = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
        if (m_phase == 0 && win >= 0) begin m_phase = 1; m_id = win; end
        else if (m_phase == 1 && ack) m_phase = 2;
        else if (m_phase == 2 && eoi) m_phase = 0;
        if (we && addr == 0) m_mask = wd[3:0];
        m_pend = np;
        m_prev = irq;
        m_armed = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_req"}, 32'(irq_req), 32'(m_phase == 1));
        chk({tag, "_id"}, 32'(irq_id), 32'(m_id));
        chk({tag, "_vec"}, irq_vec, 32'h10 + 32'(m_id) * 2);
        for (int a = 0; a < 4; a++) begin
            logic [31:0] e;
            cfg_addr = 2'(a);
            #1;
            e = (a == 0) ? 32'(m_mask) : (a == 1) ? 32'(m_pend) :
                (a == 2) ? 32'(m_phase * 4 + m_id) : 32'd0;
            chk($sformatf("%s_rd%0d", tag, a), 32'(cfg_rdata), e);
        end
    endtask

    task automatic step(input string tag, input bit [3:0] irq, input bit we = 0,
                        input bit [1:0] addr = 0, input bit [15:0] wd = 0,
                        input bit ack = 0, input bit eoi = 0);
        irq_in = irq; cfg_we = we; cfg_addr = addr; cfg_wdata = wd; irq_ack = ack; irq_eoi = eoi;
        @(posedge clk);
        model_edge(irq, we, addr, wd, ack, eoi);
        #1;
        check_all(tag);
    endtask

    initial begin
        int rises;
        bit prev_req;
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_vec", irq_vec, 32'h10);
        check_all("rst");
        rst = 1'b0;

        // 1: single line through the whole handshake
        step("t1_mask", 4'b0000, 1, 0, 16'hF);
        step("t1_edge", 4'b0100);
        chk("t1_noreq_yet", 32'(irq_req), 32'd0);
        step("t1_req", 4'b0000);
        chk("t1_req_const", 32'(irq_req), 32'd1);
        chk("t1_vec_const", irq_vec, 32'h14);
        step("t1_ack", 4'b0000, 0, 0, 0, 1, 0);
        step("t1_eoi", 4'b0000, 0, 0, 0, 0, 1);

        // 2: simultaneous edges, lowest index first, higher follows unprompted
        step("t2_edge", 4'b1010);
        step("t2_req1", 4'b0000);
        chk("t2_vec1", irq_vec, 32'h12);
        step("t2_ack1", 4'b0000, 0, 0, 0, 1, 0);
        step("t2_eoi1", 4'b0000, 0, 0, 0, 0, 1);
        step("t2_req3", 4'b0000);
        chk("t2_vec3", irq_vec, 32'h16);
        step("t2_ack3", 4'b0000, 0, 0, 0, 1, 0);
        step("t2_eoi3", 4'b0000, 0, 0, 0, 0, 1);

        // 3: masked line latches; unmask releases it; W1C clears it
        step("t3_mask0", 4'b0000, 1, 0, 16'h0);
        step("t3_edge", 4'b0001);
        step("t3_idle", 4'b0000);
        chk("t3_pend_noreq", 32'(irq_req), 32'd0);
        step("t3_mask1", 4'b0000, 1, 0, 16'h1);
        step("t3_req", 4'b0000);
        chk("t3_req_const", 32'(irq_req), 32'd1);
        step("t3_ack", 4'b0000, 0, 0, 0, 1, 0);
        step("t3_eoi", 4'b0000, 0, 0, 0, 0, 1);
        step("t3_mask0b", 4'b0000, 1, 0, 16'h0);
        step("t3_edge2", 4'b0001);
        step("t3_w1c", 4'b0000, 1, 1, 16'h1);
        step("t3_after", 4'b0000);

        // 4: new edge on the acked line survives the ack clear
        step("t4_mask", 4'b0000, 1, 0, 16'hF);
        step("t4_edge", 4'b0001);
        step("t4_req", 4'b0000);
        step("t4_ackedge", 4'b0001, 0, 0, 0, 1, 0);
        cfg_addr = 2'd1; #0;
        chk("t4_pend0", 32'(cfg_rdata[0]), 32'd1);
        step("t4_eoi", 4'b0000, 0, 0, 0, 0, 1);
        step("t4_rereq", 4'b0000);
        chk("t4_rereq_const", 32'(irq_req), 32'd1);
        step("t4_ack2", 4'b0000, 0, 0, 0, 1, 0);
        step("t4_eoi2", 4'b0000, 0, 0, 0, 0, 1);

        // 5: a held level is serviced exactly once
        rises = 0;
        prev_req = 0;
        for (int c = 0; c < 10; c++) begin
            step("t5", 4'b0010, 0, 0, 0, m_phase == 1, m_phase == 2);
            if (irq_req && !prev_req) rises++;
            prev_req = irq_req;
        end
        chk("t5_services", 32'(rises), 32'd1);
        step("t5_drop", 4'b0000, 0, 0, 0, 0, m_phase == 2);

        // 6: async reset mid-REQ; a line held through reset needs a new edge
        step("t6_edge", 4'b1000);
        step("t6_req", 4'b1000);
        chk("t6_req_const", 32'(irq_req), 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t6_req_drop", 32'(irq_req), 32'd0);
        check_all("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        step("t6_mask", 4'b1000, 1, 0, 16'hF);
        step("t6_held1", 4'b1000);
        step("t6_held2", 4'b1000);
        chk("t6_no_fire", 32'(irq_req), 32'd0);
        step("t6_fall", 4'b0000);
        step("t6_rise", 4'b1000);
        step("t6_req2", 4'b1000);
        chk("t6_req2_const", 32'(irq_req), 32'd1);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit we;
            we = ($urandom_range(0, 9) == 0);
            step("rnd", 4'($urandom), we, 2'($urandom), 16'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
